ysyx_22040632_imif_axi_rd_bridge: RTL and testbench

Responder end of the imif request interface. Accepts single or burst read requests from an imif master (the instruction cache), issues one AXI4 AR transaction per request, and streams R beats back as per-beat data/handshake strobes. Sits between the icache and the AXI crossbar/arbiter.

---
 rtl/ysyx_22040632_imif_axi_rd_bridge.sv | 158 +++++++++++++++
 tb/tb_ysyx_22040632_imif_axi_rd_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_imif_axi_rd_bridge.sv
// ysyx_22040632_imif_axi_rd_bridge
// Responder end of the imif request interface (icache side). Each read request,
// single beat or burst, becomes one AXI4 AR transaction. The R beats come back
// to the master as per-beat data and handshake strobes. Write requests are not
// supported: they return a completion pulse with err set and produce no AXI traffic.
//
// Ports:
//   clk, rrst_n              clock, asynchronous active-low reset
//   rw_valid/rw_ready        request handshake (rw_ready is a one-cycle completion pulse)
//   rw_req/addr/len/size     request type, start address, beats-1, AXI size code
//   data_read, r_hs, r_last  beat data and per-beat accept / final-beat strobes
//   err                      sticky error flag (write request, bad rresp, length mismatch)
//   ar*                      AXI4 read address channel (master side)
//   r*                       AXI4 read data channel (master side)
//
// Optional build macro: YSYX_22040632_IMIF_LEN_CHECK_EN
//   Adds a beat counter. The counter checks rlast against the requested length
//   and ends the burst on beat len+1 even if rlast never arrives.
//
// state  | meaning
// S_IDLE  | waiting for a request; no AXI activity
// S_AR    | arvalid asserted with latched addr/len/size
// S_RDATA | rready asserted, streaming beats to the master
// S_WRERR | unsupported write: completion pulse, err set

module ysyx_22040632_imif_axi_rd_bridge #(
  parameter int   ADDR_W   = 32,
  parameter int   DATA_W   = 64,
  parameter int   AXI_ID   = 0,
  parameter logic REQ_READ = 1'b0
) (
  input  logic              clk,
  input  logic              rrst_n,
  input  logic              rw_valid,
  output logic              rw_ready,
  input  logic              rw_req,
  input  logic [ADDR_W-1:0] rw_addr,
  input  logic [7:0]        rw_len,
  input  logic [2:0]        rw_size,
  output logic [DATA_W-1:0] data_read,
  output logic              r_hs,
  output logic              r_last,
  output logic              err,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_RDATA, S_WRERR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              beat_end;
  logic              beat_err;

  // AR fields come only from the latches, so they stay stable while arvalid is high.
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arid    = 4'(AXI_ID);
  assign arburst = 2'b01;
  assign err     = err_q;

  // The current beat is passed straight through. Between beats the last captured beat is held.
  assign data_read = r_hs ? rdata : data_q;

`ifdef YSYX_22040632_IMIF_LEN_CHECK_EN
  logic [7:0] beat_cnt_q;
  logic       cnt_at_len;

  assign cnt_at_len = (beat_cnt_q == len_q);
  // Either an early rlast or the expected final beat ends the burst. Any
  // disagreement between rlast and the count is flagged.
  assign beat_end   = rlast || cnt_at_len;
  assign beat_err   = rlast != cnt_at_len;

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      beat_cnt_q <= 8'd0;
    end else if (arvalid && arready) begin
      beat_cnt_q <= 8'd0;
    end else if (r_hs) begin
      beat_cnt_q <= beat_cnt_q + 8'd1;
    end
  end
`else
  assign beat_end = rlast;
  assign beat_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    arvalid  = 1'b0;
    rready   = 1'b0;
    r_hs     = 1'b0;
    r_last   = 1'b0;
    rw_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rw_valid) begin
          state_d = (rw_req == REQ_READ) ? S_AR : S_WRERR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        rready   = 1'b1;
        r_hs     = rvalid;
        r_last   = rvalid && beat_end;
        rw_ready = rvalid && beat_end;
        if (rvalid && beat_end) state_d = S_IDLE;
      end
      S_WRERR: begin
        rw_ready = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && rw_valid && rw_req == REQ_READ) begin
        addr_q <= rw_addr;
        len_q  <= rw_len;
        size_q <= rw_size;
      end
      if (r_hs) data_q <= rdata;
      if (state_q == S_WRERR || (r_hs && (rresp != 2'b00 || beat_err))) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_imif_axi_rd_bridge.sv
// Testbench for ysyx_22040632_imif_axi_rd_bridge.
// Directed scenarios plus randomized reads. An AXI responder and the expected
// behaviour are modelled at transaction level in this bench.
module tb_ysyx_22040632_imif_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        rrst_n;
  logic        rw_valid, rw_ready, rw_req;
  logic [31:0] rw_addr;
  logic [7:0]  rw_len;
  logic [2:0]  rw_size;
  logic [63:0] data_read;
  logic        r_hs, r_last, err;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  ysyx_22040632_imif_axi_rd_bridge dut (
    .clk(clk), .rrst_n(rrst_n),
    .rw_valid(rw_valid), .rw_ready(rw_ready), .rw_req(rw_req),
    .rw_addr(rw_addr), .rw_len(rw_len), .rw_size(rw_size),
    .data_read(data_read), .r_hs(r_hs), .r_last(r_last), .err(err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clk = ~clk;

  int          total  = 0;
  int          passed = 0;
  logic [63:0] beats [256];
  logic [1:0]  resps [256];
  bit          err_exp   = 1'b0;
  logic [63:0] last_data = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_r_hs"}, r_hs, 0);
    chk({tag, "_r_last"}, r_last, 0);
    chk({tag, "_rw_ready"}, rw_ready, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_data_read"}, data_read, 0);
  endtask

  task automatic fill(input int len, input int bad_beat, input bit incr);
    for (int i = 0; i <= len; i++) begin
      beats[i] = incr ? 64'(i) : {$urandom, $urandom};
      resps[i] = (i == bad_beat) ? 2'b10 : 2'b00;
    end
  endtask

  // mode 0: no backpressure, 1: arready low 3 cycles + rvalid every other cycle, 2: random
  task automatic run_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input int mode, input int reset_after);
    int idx = 0;
    int cyc = 0;
    int ar_wait = 0;
    bit ar_done = 0;
    bit done = 0;
    bit aborted = 0;
    bit rv;
    tick();
    rw_valid = 1; rw_req = 0; rw_addr = addr; rw_len = 8'(len); rw_size = size;
    arready = 0; rvalid = 0; rlast = 0; rresp = 0;
    #3;
    chk("req_cycle_arvalid", arvalid, 0);
    chk("req_cycle_rw_ready", rw_ready, 0);
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
      rw_addr = $urandom; rw_len = 8'($urandom); rw_size = 3'($urandom);
      case (mode)
        0:       arready = 1;
        1:       arready = (ar_wait >= 3);
        default: arready = 1'($urandom_range(0, 1));
      endcase
      if (!ar_done)       rv = 0;
      else if (mode == 0) rv = 1;
      else if (mode == 1) rv = cyc[0];
      else                rv = 1'($urandom_range(0, 1));
      rvalid = rv;
      rdata  = rv ? beats[idx] : {$urandom, $urandom};
      rresp  = rv ? resps[idx] : 2'b00;
      rlast  = rv && (idx == len);
      #3;
      chk("arvalid", arvalid, !ar_done);
      if (arvalid) begin
        chk("araddr", araddr, addr);
        chk("arlen", arlen, 8'(len));
        chk("arsize", arsize, size);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 0);
        if (!arready) ar_wait++;
      end
      chk("rready", rready, ar_done);
      chk("r_hs", r_hs, rv);
      chk("err", err, err_exp);
      if (rv) begin
        chk("data_read", data_read, beats[idx]);
        chk("r_last", r_last, idx == len);
        chk("rw_ready", rw_ready, idx == len);
        last_data = beats[idx];
        if (resps[idx] != 2'b00) err_exp = 1;
        if (idx == len) done = 1;
        idx++;
      end else begin
        chk("data_hold", data_read, last_data);
        chk("r_last_idle", r_last, 0);
        chk("rw_ready_idle", rw_ready, 0);
      end
      if (rv && (idx - 1) == reset_after) begin
        #1 rrst_n = 0;
        #1;
        chk_all_zero("async_reset");
        aborted = 1;
        break;
      end
      if (arvalid && arready) ar_done = 1;
    end
    if (aborted) begin
      tick();
      rw_valid = 0; rvalid = 0; arready = 0; rlast = 0;
      #2 rrst_n = 1;
      err_exp = 0;
      last_data = 64'd0;
      return;
    end
    chk("completed", done, 1);
    chk("beats_delivered", idx, len + 1);
    if (mode == 0) chk("latency", cyc, len + 2);
    tick();
    rw_valid = 0; rvalid = 0; arready = 0; rlast = 0;
    #3;
    chk("post_arvalid", arvalid, 0);
    chk("post_rready", rready, 0);
    chk("post_rw_ready", rw_ready, 0);
    chk("post_err", err, err_exp);
  endtask

  task automatic run_write();
    int pulses = 0;
    int at = 0;
    tick();
    rw_valid = 1; rw_req = 1; rw_addr = $urandom; rw_len = 8'($urandom);
    #3;
    chk("wr_req_arvalid", arvalid, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (pulses > 0) rw_valid = 0;
      #3;
      chk("wr_arvalid", arvalid, 0);
      chk("wr_rready", rready, 0);
      if (rw_ready) begin
        pulses++;
        at = c;
      end
    end
    err_exp = 1;
    rw_req = 0;
    chk("wr_pulses", pulses, 1);
    chk("wr_latency_le2", at >= 1 && at <= 2, 1);
    chk("wr_err", err, 1);
  endtask

  initial begin
    rrst_n = 0; rw_valid = 0; rw_req = 0; rw_addr = 0; rw_len = 0; rw_size = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    repeat (3) @(posedge clk);
    #3;
    chk_all_zero("reset");
    chk("reset_araddr", araddr, 0);
    chk("reset_arlen", arlen, 0);
    rrst_n = 1;

    fill(0, -1, 0);
    beats[0] = 64'h0000_0000_1234_5678;
    run_read(32'h8000_0004, 0, 3'b010, 0, -1);

    fill(7, -1, 1);
    run_read(32'h8000_0040, 7, 3'b011, 0, -1);

    fill(7, -1, 0);
    run_read(32'h8000_1000, 7, 3'b011, 1, -1);

    fill(7, 3, 0);
    run_read(32'h8000_2000, 7, 3'b011, 2, -1);

    run_write();

    for (int t = 0; t < 10; t++) begin
      int len = $urandom_range(0, 15);
      fill(len, ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1, 0);
      run_read($urandom, len, 3'($urandom_range(0, 3)), $urandom_range(0, 2), -1);
    end

    fill(7, 1, 0);
    run_read(32'h8000_3000, 7, 3'b011, 0, 2);

    fill(0, -1, 0);
    run_read(32'h8000_0008, 0, 3'b010, 2, -1);
    chk("err_after_reset_read", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
